inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8: instruction word width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 4: entry count, a power of 2 and at least 2; ADDR_W = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all entries.
REQ-006 SHALL have port in_valid, input, 1 bit: producer offers in_data.
REQ-007 SHALL have port in_data, input, DATA_W bits: instruction word to enqueue.
REQ-008 SHALL have port in_ready, output, 1 bit: queue accepts a word this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds the oldest entry.
REQ-010 SHALL have port out_data, output, DATA_W bits: oldest entry, first-word-fall-through.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-012 SHALL have port count, output, ADDR_W+1 bits: number of stored entries.

Function
REQ-013 SHALL push when in_valid and in_ready are both 1 at a rising clk edge, writing in_data at the write pointer.
REQ-014 SHALL pop when out_valid and out_ready are both 1 at a rising clk edge, advancing the read pointer.
REQ-015 SHALL drive in_ready = (count != DEPTH) combinationally from state only, with no dependency on out_ready.
REQ-016 SHALL drive out_valid = (count != 0) combinationally from state only.
REQ-017 SHALL drive out_data from the entry at the read pointer when out_valid = 1, and 0 when out_valid = 0.
REQ-018 Latency: a word pushed into an empty queue SHALL appear on out_data with out_valid = 1 in the cycle after the push edge; there is no same-cycle bypass.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-020 Full (count = DEPTH): in_ready SHALL be 0; in_valid SHALL be ignored, even if a pop occurs in the same cycle.
REQ-021 Empty (count = 0): out_ready SHALL be ignored, and count and pointers SHALL not change due to the pop request.
REQ-022 Pointers are ADDR_W bits and SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries; count SHALL never exceed DEPTH or go below 0.
REQ-023 On flush = 1 at an edge, pointers and count SHALL become 0, overriding any push or pop in the same cycle; the word offered that cycle is dropped.
REQ-024 in_data, in_valid and out_ready values SHALL not affect state when reset or flush is active.
REQ-025 Entries SHALL be written only on push; storage contents are not required to be cleared by flush.

Reset
REQ-026 While reset = 1, regardless of clk, the block SHALL hold pointers = 0 and count = 0, giving out_valid = 0, out_data = 0 and in_ready = 1.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately; the first push after reset deassertion SHALL be the first word output.
REQ-028 Storage array reset is not required; outputs SHALL still meet REQ-026 through the out_valid gating of REQ-017.

Verification (DATA_W=8, DEPTH=4)
REQ-029 Reset then push 0xA1 with out_ready=0: next cycle out_valid=1, out_data=0xA1, count=1.
REQ-030 Push 0x11,0x22,0x33,0x44, then hold in_valid with 0x55 while out_ready=0: count=4, in_ready=0, 0x55 not stored; pop four times yields 0x11,0x22,0x33,0x44, then out_valid=0, out_data=0.
REQ-031 Continuous push and pop for 10 words 0x00..0x09 at count=2: count stays 2 and output order is preserved across pointer wrap.
REQ-032 Fill with 3 words, assert flush with in_valid=1, data 0x77: next cycle count=0, out_valid=0; 0x77 never appears.
REQ-033 With count=3, assert reset asynchronously between edges: out_valid=0, count=0 and in_ready=1 without waiting for clk; after release, push 0x5A gives out_data=0x5A.
REQ-034 Pop request on empty queue with out_ready=1 for 3 cycles: count stays 0 and no underflow occurs; a subsequent push of 0xC3 reads back 0xC3.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue: first-word-fall-through FIFO with registered occupancy,
// synchronous flush and asynchronous active-high reset.
module inst_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  // Valid/ready: a transfer happens on a rising edge only when valid and ready
  // are both 1; ready/valid here depend on stored state only, never on the peer.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; out_valid gating keeps stale words off out_data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue (DATA_W=8, DEPTH=4): table vectors, directed corner
// sequences and random traffic, all checked against a queue-based scoreboard.
module tb_inst_queue;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;

  int n_vec;
  int n_err;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic [2:0]    e_cnt;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t vecs[12];

  inst_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: inputs change just after the falling edge, sampled 1ns later
  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  // scoreboard: check outputs against the reference queue, then advance it
  task automatic sb_tick();
    int sz;
    sz = exp_q.size();
    chk("sb_count", 32'(count), 32'(sz));
    chk("sb_in_ready", 32'(in_ready), 32'(sz != DP));
    chk("sb_out_valid", 32'(out_valid), 32'(sz != 0));
    if (sz != 0) chk("sb_out_data", 32'(out_data), 32'(exp_q[0]));
    else         chk("sb_out_data_empty", 32'(out_data), 32'(0));
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_ready && sz > 0) void'(exp_q.pop_front());
      if (in_valid && sz < DP) exp_q.push_back(in_data);
    end
    @(posedge clk);
  endtask

  task automatic step(input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
    drive(fl, iv, id, ordy);
    sb_tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // reset state, held with the clock running
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // fl, iv, id, ordy | count, in_ready, out_valid, out_data (before the edge)
    vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'hA1};
    vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11};
    vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h44, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11};
    vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11};
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd4, 1'b0, 1'b1, 8'h11};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'h33};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'h44};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      sb_tick();
    end

    // streaming at count=2 across pointer wrap
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 2; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b1);
      chk("stream_count", 32'(count), 32'(2));
      sb_tick();
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // flush drops the word offered in the same cycle
    step(1'b0, 1'b1, 8'hE1, 1'b0);
    step(1'b0, 1'b1, 8'hE2, 1'b0);
    step(1'b0, 1'b1, 8'hE3, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    sb_tick();

    // asynchronous reset between edges at count=3
    step(1'b0, 1'b1, 8'hB1, 1'b0);
    step(1'b0, 1'b1, 8'hB2, 1'b0);
    step(1'b0, 1'b1, 8'hB3, 1'b0);
    #2;
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_count", 32'(count), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_out_data", 32'(out_data), 32'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("arst_first_word", 32'(out_data), 32'(8'h5A));
    sb_tick();

    // pop requests on an empty queue
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("empty_pop_count", 32'(count), 32'(0));
      sb_tick();
    end
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("empty_then_push", 32'(out_data), 32'(8'hC3));
    sb_tick();

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
